lane_pipe_chain: RTL and testbench
==================================

# lane_pipe_chain

Parametrised multi-lane, multi-stage back-end pipeline register chain, replacing the fixed dual-issue EX→MEM→WB register block. It carries LANES in-order issue lanes through STAGES register stages with per-lane valid/write-enable tracking. Its own logic handles global stall, CSR/exception flush, oldest-lane branch redirect with single-fire guarantee under stall, and exception-based write suppression of younger lanes at the final stage. It sits between the EX stage outputs and the register-file write port.

## Interface
- LANES, 2, issue lanes (1..4); lane 0 is oldest.
- STAGES, 2, register stages (2..4); stage 1 = MEM, stage STAGES = WB, stage STAGES-1 = "mid".
- DW, 32, per-lane payload/result width.
- clk  in  1  clock.
- rstn  in  1  reset, synchronous, active-low.
- stall  in  1  global hold; no stage advances.
- flush  in  1  CSR/exception flush; clears every stage's valid.
- in_valid, in_we, in_br  in  LANES each  EX lane valid, rf write enable, branch mispredict flag.
- in_waddr  in  5*LANES  rf write address.
- in_pc, in_br_pc  in  32*LANES each  lane PC, corrected target.
- in_data  in  DW*LANES  EX result.
- mid_ecode  in  7*LANES  exception code of mid-stage lanes, 0 = none (combinational from MEM logic).
- mid_wdata  in  DW*LANES  final rf write data computed from mid-stage outputs.
- s1_valid  out  LANES  stage-1 valid, younger-than-branch lanes masked.
- mid_valid, mid_we  out  LANES each;  mid_pc  out  32*LANES;  mid_data  out  DW*LANES;  mid_waddr  out  5*LANES.
- wb_we  out  LANES;  wb_waddr  out  5*LANES;  wb_wdata  out  DW*LANES;  wb_pc  out  32*LANES.
- redirect_valid  out  1;  redirect_pc  out  32;  redirect_lane  out  2.
- exc_valid  out  1;  exc_lane  out  2  (oldest excepting mid lane, combinational).

## Operation
- advance = ~stall. On advance every stage k captures stage k-1 (stage 1 captures in_*); else all stages hold.
- Priority at each edge: ~rstn > flush > redirect kill > advance > hold.
- ~rstn or flush: all valid/we bits and fired cleared; data/PC/addr fields not reset.
- Redirect: br_lane = lowest lane with s1 valid & br. redirect_valid = any & ~fired & ~flush; redirect_pc/lane from br_lane.
- s1_valid[i] = valid[i] & ~(any & i > br_lane), combinational.
- fired: set when redirect_valid & stall; cleared on advance or flush. Prevents refire while stage 1 holds.
- On advance with (redirect_valid | fired): stage 1 captures a bubble (all valid=0); stage 2 takes masked s1 lanes (killed lanes valid=0, we=0).
- Intermediate stages (STAGES>2) pass valid/we/waddr/data/pc unchanged.
- Final stage: wb_we[i] = mid_valid[i] & mid_we[i] & (mid_ecode[j]==0 for all j ≤ i); wb_wdata = mid_wdata.
- exc_valid = any mid lane valid with nonzero ecode; exc_lane = lowest such.

## Timing
- Latency EX→WB: STAGES cycles with no stall.
- redirect_valid: combinational from stage-1 state, at most one cycle high per branch instance, including across multi-cycle stall.
- flush at edge t: all valid=0 from t+1; redirect_valid forced 0 during the flush cycle.
- Reset values: all valid, we, wb_we, fired, redirect_valid, exc_valid = 0; redirect_pc/lane, data fields undefined until first capture.
- Simultaneous stall & flush: flush wins.
- Simultaneous redirect & mid exception: both reported; the control unit asserts flush next.

## Test plan
- LANES=2, STAGES=2, no stall, lane0 we=1 waddr=5 data=0x11, lane1 waddr=6 → wb_we=2'b11, waddr 5/6 after 2 cycles; wb_wdata = mid_wdata.
- Stage-1 lane0 br=1 br_pc=0x1C000100, lane1 we=1 → redirect_valid=1 for 1 cycle, pc=0x1C000100, lane=0; s1_valid=2'b01; lane1 never writes; next stage-1 = bubble.
- Same branch held with stall 3 cycles → redirect_valid high only in first cycle; after release stage 1 = bubble.
- mid_ecode lane0=0x08 with both we=1 → wb_we=2'b00, exc_lane=0; lane1 only nonzero → wb_we=2'b01.
- flush with stall=1 and full pipeline → all valid/wb_we 0 next cycle; redirect_valid 0 in flush cycle.
- LANES=4, STAGES=3, branch on lane2 → lane3 killed, lanes 0-2 reach WB after 3 cycles; rstn=0 mid-run clears all valids next edge.

Source files
------------

// File: rtl/lane_pipe_chain.sv
// lane_pipe_chain
// Multi-lane, multi-stage back-end register chain (EX -> MEM ... -> WB).
// Carries LANES in-order issue lanes (lane 0 oldest) through STAGES register
// stages with per-lane valid / write-enable tracking. It handles global stall,
// flush, oldest-lane branch redirect (fires once per branch, even across a
// stall) and exception-based suppression of younger-lane writes at WB.
//
// Ports
//   clk, rstn            clock, synchronous active-low reset
//   stall                global hold, no stage advances
//   flush                clears every stage's valid / write enable
//   in_valid/we/br       EX lane valid, rf write enable, branch mispredict
//   in_waddr/pc/br_pc    EX rf write address, lane PC, corrected target
//   in_data              EX result
//   mid_ecode            exception code of mid-stage lanes (0 = none)
//   mid_wdata            final rf write data computed from mid-stage outputs
//   s1_valid             stage-1 valid with lanes younger than a branch masked
//   mid_*                mid-stage (stage STAGES-1) state
//   wb_*                 register-file write port (stage STAGES)
//   redirect_*           branch redirect request from stage 1
//   exc_valid/exc_lane   oldest excepting mid-stage lane
module lane_pipe_chain #(
  parameter int LANES  = 2,
  parameter int STAGES = 2,
  parameter int DW     = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [LANES-1:0]      in_valid,
  input  logic [LANES-1:0]      in_we,
  input  logic [LANES-1:0]      in_br,
  input  logic [5*LANES-1:0]    in_waddr,
  input  logic [32*LANES-1:0]   in_pc,
  input  logic [32*LANES-1:0]   in_br_pc,
  input  logic [DW*LANES-1:0]   in_data,
  input  logic [7*LANES-1:0]    mid_ecode,
  input  logic [DW*LANES-1:0]   mid_wdata,
  output logic [LANES-1:0]      s1_valid,
  output logic [LANES-1:0]      mid_valid,
  output logic [LANES-1:0]      mid_we,
  output logic [32*LANES-1:0]   mid_pc,
  output logic [DW*LANES-1:0]   mid_data,
  output logic [5*LANES-1:0]    mid_waddr,
  output logic [LANES-1:0]      wb_we,
  output logic [5*LANES-1:0]    wb_waddr,
  output logic [DW*LANES-1:0]   wb_wdata,
  output logic [32*LANES-1:0]   wb_pc,
  output logic                  redirect_valid,
  output logic [31:0]           redirect_pc,
  output logic [1:0]            redirect_lane,
  output logic                  exc_valid,
  output logic [1:0]            exc_lane
);

  // Number of register stages ahead of WB (stage 1 .. mid).
  localparam int NM = STAGES - 1;

  // Pre-WB stage registers, indexed by stage number 1..NM.
  logic [NM:1][LANES-1:0]          vld_p;
  logic [NM:1][LANES-1:0]          we_p;
  logic [NM:1][LANES-1:0][4:0]     waddr_p;
  logic [NM:1][LANES-1:0][31:0]    pc_p;
  logic [NM:1][LANES-1:0][DW-1:0]  data_p;
  logic [LANES-1:0]                br_p1;
  logic [LANES-1:0][31:0]          br_pc_p1;
  logic                            fired;

  // Effective (kill-masked) valid / we per stage.
  logic [NM:1][LANES-1:0]          vld_e;
  logic [NM:1][LANES-1:0]          we_e;
  logic [LANES-1:0]                kill;
  logic                            any_br;
  int                              br_idx;
  logic                            kill_s1;
  logic                            advance;

  logic [LANES-1:0][6:0]           ecode;
  logic [LANES-1:0]                wb_we_d;
  logic                            exc_seen;
  int                              exc_idx;

  assign advance = ~stall;
  assign ecode   = mid_ecode;

  // Oldest branching lane in stage 1 and the lanes younger than it.
  always_comb begin
    any_br      = 1'b0;
    br_idx      = 0;
    kill        = '0;
    redirect_pc = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (vld_p[1][i] && br_p1[i]) begin
        any_br = 1'b1;
        br_idx = i;
      end
    end
    for (int i = 0; i < LANES; i++) begin
      kill[i] = any_br && (i > br_idx);
      if (i == br_idx) redirect_pc = br_pc_p1[i];
    end
    vld_e    = vld_p;
    we_e     = we_p;
    vld_e[1] = vld_p[1] & ~kill;
    we_e[1]  = we_p[1] & ~kill;
  end

  assign s1_valid       = vld_e[1];
  assign redirect_lane  = 2'(br_idx);
  // While fired is set the branch is still parked in stage 1 behind a stall;
  // it must not be reported again, but its younger lanes still die.
  assign redirect_valid = any_br & ~fired & ~flush;
  assign kill_s1        = redirect_valid | fired;

  assign mid_valid = vld_e[NM];
  assign mid_we    = we_e[NM];
  assign mid_pc    = pc_p[NM];
  assign mid_data  = data_p[NM];
  assign mid_waddr = waddr_p[NM];

  // A lane may write only if neither it nor any older lane is excepting.
  always_comb begin
    exc_seen  = 1'b0;
    exc_valid = 1'b0;
    exc_idx   = 0;
    wb_we_d   = '0;
    for (int i = 0; i < LANES; i++) begin
      if (ecode[i] != 7'd0) exc_seen = 1'b1;
      wb_we_d[i] = mid_valid[i] & mid_we[i] & ~exc_seen;
    end
    for (int i = LANES - 1; i >= 0; i--) begin
      if (mid_valid[i] && (ecode[i] != 7'd0)) begin
        exc_valid = 1'b1;
        exc_idx   = i;
      end
    end
  end

  assign exc_lane = 2'(exc_idx);

  // ---- control state: valid / we / fired ----
  always_ff @(posedge clk) begin
    if (!rstn || flush) begin
      vld_p <= '0;
      we_p  <= '0;
      wb_we <= '0;
      fired <= 1'b0;
    end else if (advance) begin
      vld_p[1] <= kill_s1 ? '0 : in_valid;
      we_p[1]  <= kill_s1 ? '0 : in_we;
      for (int k = 2; k <= NM; k++) begin
        vld_p[k] <= vld_e[k-1];
        we_p[k]  <= we_e[k-1];
      end
      wb_we <= wb_we_d;
      fired <= 1'b0;
    end else if (redirect_valid) begin
      fired <= 1'b1;
    end
  end

  // ---- data path: stage 1 .. mid .. WB ----
  always_ff @(posedge clk) begin
    if (advance) begin
      br_p1      <= in_br;
      br_pc_p1   <= in_br_pc;
      waddr_p[1] <= in_waddr;
      pc_p[1]    <= in_pc;
      data_p[1]  <= in_data;
      for (int k = 2; k <= NM; k++) begin
        waddr_p[k] <= waddr_p[k-1];
        pc_p[k]    <= pc_p[k-1];
        data_p[k]  <= data_p[k-1];
      end
      wb_waddr <= waddr_p[NM];
      wb_wdata <= mid_wdata;
      wb_pc    <= pc_p[NM];
    end
  end

endmodule

// File: tb/tb_lane_pipe_chain.sv
module tb_lane_pipe_chain;

  logic clk;
  int   checks   = 0;
  int   failures = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- DUT A: LANES=2, STAGES=2 ----------------
  logic        rstn_a, stall_a, flush_a;
  logic [1:0]  v_a, we_a, br_a;
  logic [9:0]  waddr_a;
  logic [63:0] pc_a, brpc_a, data_a, mwd_a;
  logic [13:0] ecode_a;
  logic [1:0]  s1_a, midv_a, midwe_a, wbwe_a, rl_a, exl_a;
  logic [63:0] midpc_a, middata_a, wbwd_a, wbpc_a;
  logic [9:0]  midwa_a, wbwa_a;
  logic        rv_a, exv_a;
  logic [31:0] rpc_a;

  lane_pipe_chain #(.LANES(2), .STAGES(2), .DW(32)) dut_a (
    .clk(clk), .rstn(rstn_a), .stall(stall_a), .flush(flush_a),
    .in_valid(v_a), .in_we(we_a), .in_br(br_a), .in_waddr(waddr_a),
    .in_pc(pc_a), .in_br_pc(brpc_a), .in_data(data_a),
    .mid_ecode(ecode_a), .mid_wdata(mwd_a),
    .s1_valid(s1_a), .mid_valid(midv_a), .mid_we(midwe_a), .mid_pc(midpc_a),
    .mid_data(middata_a), .mid_waddr(midwa_a),
    .wb_we(wbwe_a), .wb_waddr(wbwa_a), .wb_wdata(wbwd_a), .wb_pc(wbpc_a),
    .redirect_valid(rv_a), .redirect_pc(rpc_a), .redirect_lane(rl_a),
    .exc_valid(exv_a), .exc_lane(exl_a)
  );

  // ---------------- DUT B: LANES=4, STAGES=3 ----------------
  logic         rstn_b, stall_b, flush_b;
  logic [3:0]   v_b, we_b, br_b;
  logic [19:0]  waddr_b;
  logic [127:0] pc_b, brpc_b, data_b, mwd_b;
  logic [27:0]  ecode_b;
  logic [3:0]   s1_b, midv_b, midwe_b, wbwe_b;
  logic [1:0]   rl_b, exl_b;
  logic [127:0] midpc_b, middata_b, wbwd_b, wbpc_b;
  logic [19:0]  midwa_b, wbwa_b;
  logic         rv_b, exv_b;
  logic [31:0]  rpc_b;

  lane_pipe_chain #(.LANES(4), .STAGES(3), .DW(32)) dut_b (
    .clk(clk), .rstn(rstn_b), .stall(stall_b), .flush(flush_b),
    .in_valid(v_b), .in_we(we_b), .in_br(br_b), .in_waddr(waddr_b),
    .in_pc(pc_b), .in_br_pc(brpc_b), .in_data(data_b),
    .mid_ecode(ecode_b), .mid_wdata(mwd_b),
    .s1_valid(s1_b), .mid_valid(midv_b), .mid_we(midwe_b), .mid_pc(midpc_b),
    .mid_data(middata_b), .mid_waddr(midwa_b),
    .wb_we(wbwe_b), .wb_waddr(wbwa_b), .wb_wdata(wbwd_b), .wb_pc(wbpc_b),
    .redirect_valid(rv_b), .redirect_pc(rpc_b), .redirect_lane(rl_b),
    .exc_valid(exv_b), .exc_lane(exl_b)
  );

  // One row = inputs applied during a cycle + outputs expected in that cycle
  // (registered outputs reflect the previous edge).
  typedef struct packed {
    logic       rstn, stall, flush;
    logic [1:0] v, we, br;
    logic [4:0] wa0, wa1;
    logic [6:0] ec0, ec1;
    logic       chk;
    logic [1:0] s1, wbwe;
    logic       rv;
    logic [1:0] rl;
    logic       exv;
    logic [1:0] exl;
    logic       chka;
    logic [9:0] addr;
  } vec_t;

  localparam int NV = 27;
  vec_t tbl [NV];

  function automatic vec_t mk(
    input logic rstn, stall, flush, input logic [1:0] v, we, br,
    input logic [4:0] wa0, wa1, input logic [6:0] ec0, ec1,
    input logic chk, input logic [1:0] s1, wbwe, input logic rv,
    input logic [1:0] rl, input logic exv, input logic [1:0] exl,
    input logic chka, input logic [9:0] addr);
    vec_t t;
    t.rstn = rstn; t.stall = stall; t.flush = flush;
    t.v = v; t.we = we; t.br = br; t.wa0 = wa0; t.wa1 = wa1;
    t.ec0 = ec0; t.ec1 = ec1; t.chk = chk; t.s1 = s1; t.wbwe = wbwe;
    t.rv = rv; t.rl = rl; t.exv = exv; t.exl = exl; t.chka = chka; t.addr = addr;
    return t;
  endfunction

  function automatic logic [63:0] mwd_of(input int r);
    return {32'hB000_0000 | 32'(r), 32'hA000_0000 | 32'(r)};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  initial begin
    vec_t t;
    //            rst st fl v     we    br    wa0 wa1 ec0 ec1  chk s1    wbwe  rv rl exv exl chka addr
    tbl[0]  = mk(0, 0, 0, 2'b00, 2'b00, 2'b00, 0,  0,  0,  0,   0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 10'd0);
    tbl[1]  = mk(1, 0, 0, 2'b00, 2'b00, 2'b00, 0,  0,  0,  0,   1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 10'd0);
    tbl[2]  = mk(1, 0, 0, 2'b11, 2'b11, 2'b00, 5,  6,  0,  0,   1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 10'd0);
    tbl[3]  = mk(1, 0, 0, 2'b00, 2'b00, 2'b00, 0,  0,  0,  0,   1, 2'b11, 2'b00, 0, 0, 0, 0, 0, 10'd0);
    tbl[4]  = mk(1, 0, 0, 2'b00, 2'b00, 2'b00, 0,  0,  0,  0,   1, 2'b00, 2'b11, 0, 0, 0, 0, 1, {5'd6, 5'd5});
    // branch on lane 0: one-cycle redirect, lane 1 killed, next stage 1 bubble
    tbl[5]  = mk(1, 0, 0, 2'b11, 2'b11, 2'b01, 7,  8,  0,  0,   1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 10'd0);
    tbl[6]  = mk(1, 0, 0, 2'b11, 2'b11, 2'b00, 9,  10, 0,  0,   1, 2'b01, 2'b00, 1, 0, 0, 0, 0, 10'd0);
    tbl[7]  = mk(1, 0, 0, 2'b00, 2'b00, 2'b00, 0,  0,  0,  0,   1, 2'b00, 2'b01, 0, 0, 0, 0, 1, {5'd8, 5'd7});
    tbl[8]  = mk(1, 0, 0, 2'b00, 2'b00, 2'b00, 0,  0,  0,  0,   1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 10'd0);
    // same branch held by a 3-cycle stall: redirect only in first cycle
    tbl[9]  = mk(1, 0, 0, 2'b11, 2'b11, 2'b01, 11, 12, 0,  0,   1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 10'd0);
    tbl[10] = mk(1, 1, 0, 2'b11, 2'b11, 2'b00, 0,  0,  0,  0,   1, 2'b01, 2'b00, 1, 0, 0, 0, 0, 10'd0);
    tbl[11] = mk(1, 1, 0, 2'b00, 2'b00, 2'b00, 0,  0,  0,  0,   1, 2'b01, 2'b00, 0, 0, 0, 0, 0, 10'd0);
    tbl[12] = mk(1, 1, 0, 2'b00, 2'b00, 2'b00, 0,  0,  0,  0,   1, 2'b01, 2'b00, 0, 0, 0, 0, 0, 10'd0);
    tbl[13] = mk(1, 0, 0, 2'b11, 2'b11, 2'b00, 13, 14, 0,  0,   1, 2'b01, 2'b00, 0, 0, 0, 0, 0, 10'd0);
    tbl[14] = mk(1, 0, 0, 2'b00, 2'b00, 2'b00, 0,  0,  0,  0,   1, 2'b00, 2'b01, 0, 0, 0, 0, 1, {5'd12, 5'd11});
    tbl[15] = mk(1, 0, 0, 2'b00, 2'b00, 2'b00, 0,  0,  0,  0,   1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 10'd0);
    // mid exceptions: lane 0 suppresses both, lane 1 only suppresses itself
    tbl[16] = mk(1, 0, 0, 2'b11, 2'b11, 2'b00, 15, 16, 0,  0,   1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 10'd0);
    tbl[17] = mk(1, 0, 0, 2'b00, 2'b00, 2'b00, 0,  0,  8,  0,   1, 2'b11, 2'b00, 0, 0, 1, 0, 0, 10'd0);
    tbl[18] = mk(1, 0, 0, 2'b00, 2'b00, 2'b00, 0,  0,  0,  0,   1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 10'd0);
    tbl[19] = mk(1, 0, 0, 2'b11, 2'b11, 2'b00, 17, 18, 0,  0,   1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 10'd0);
    tbl[20] = mk(1, 0, 0, 2'b00, 2'b00, 2'b00, 0,  0,  0,  8,   1, 2'b11, 2'b00, 0, 0, 1, 1, 0, 10'd0);
    tbl[21] = mk(1, 0, 0, 2'b00, 2'b00, 2'b00, 0,  0,  0,  0,   1, 2'b00, 2'b01, 0, 0, 0, 0, 1, {5'd18, 5'd17});
    // full pipeline, branch in stage 1, flush together with stall
    tbl[22] = mk(1, 0, 0, 2'b11, 2'b11, 2'b00, 19, 20, 0,  0,   1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 10'd0);
    tbl[23] = mk(1, 0, 0, 2'b11, 2'b11, 2'b01, 21, 22, 0,  0,   1, 2'b11, 2'b00, 0, 0, 0, 0, 0, 10'd0);
    tbl[24] = mk(1, 1, 1, 2'b00, 2'b00, 2'b00, 0,  0,  0,  0,   1, 2'b01, 2'b11, 0, 0, 0, 0, 1, {5'd20, 5'd19});
    tbl[25] = mk(1, 0, 0, 2'b00, 2'b00, 2'b00, 0,  0,  0,  0,   1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 10'd0);
    tbl[26] = mk(1, 0, 0, 2'b00, 2'b00, 2'b00, 0,  0,  0,  0,   1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 10'd0);

    // idle defaults for both DUTs
    rstn_a = 0; stall_a = 0; flush_a = 0; v_a = 0; we_a = 0; br_a = 0;
    waddr_a = 0; pc_a = 0; data_a = 0; ecode_a = 0; mwd_a = 0;
    brpc_a = {32'h1C00_0200, 32'h1C00_0100};
    rstn_b = 0; stall_b = 0; flush_b = 0; v_b = 0; we_b = 0; br_b = 0;
    waddr_b = 0; pc_b = 0; data_b = 0; ecode_b = 0; mwd_b = {4{32'h5A5A_0000}};
    brpc_b = {32'h1C00_0400, 32'h1C00_0300, 32'h1C00_0200, 32'h1C00_0100};

    @(posedge clk); #1;

    for (int r = 0; r < NV; r++) begin
      t = tbl[r];
      rstn_a  = t.rstn; stall_a = t.stall; flush_a = t.flush;
      v_a     = t.v; we_a = t.we; br_a = t.br;
      waddr_a = {t.wa1, t.wa0};
      pc_a    = {32'h1000_0000 | 32'(t.wa1), 32'h1000_0000 | 32'(t.wa0)};
      data_a  = {27'd0, t.wa1, 27'd0, t.wa0};
      ecode_a = {t.ec1, t.ec0};
      mwd_a   = mwd_of(r);
      #4;
      if (t.chk) begin
        chk($sformatf("a_r%0d_s1_valid", r), 128'(s1_a), 128'(t.s1));
        chk($sformatf("a_r%0d_wb_we", r), 128'(wbwe_a), 128'(t.wbwe));
        chk($sformatf("a_r%0d_redirect_valid", r), 128'(rv_a), 128'(t.rv));
        chk($sformatf("a_r%0d_exc_valid", r), 128'(exv_a), 128'(t.exv));
        if (t.rv) begin
          chk($sformatf("a_r%0d_redirect_lane", r), 128'(rl_a), 128'(t.rl));
          chk($sformatf("a_r%0d_redirect_pc", r), 128'(rpc_a), 128'(32'h1C00_0100));
        end
        if (t.exv) chk($sformatf("a_r%0d_exc_lane", r), 128'(exl_a), 128'(t.exl));
        if (t.chka) begin
          chk($sformatf("a_r%0d_wb_waddr", r), 128'(wbwa_a), 128'(t.addr));
          chk($sformatf("a_r%0d_wb_wdata", r), 128'(wbwd_a), 128'(mwd_of(r - 1)));
        end
      end
      @(posedge clk); #1;
    end
    // after the flush row the mid stage must also be empty
    chk("a_mid_valid_after_flush", 128'(midv_a), 128'(2'b00));

    // ---- DUT B: 4 lanes, 3 stages, branch on lane 2 ----
    rstn_b = 0; @(posedge clk); #1;
    rstn_b = 1; #4;
    chk("b_reset_s1_valid", 128'(s1_b), 128'(4'b0000));
    chk("b_reset_mid_valid", 128'(midv_b), 128'(4'b0000));
    chk("b_reset_wb_we", 128'(wbwe_b), 128'(4'b0000));
    chk("b_reset_redirect", 128'(rv_b), 128'(1'b0));
    @(posedge clk); #1;
    v_b = 4'hF; we_b = 4'hF; br_b = 4'b0100;
    waddr_b = {5'd4, 5'd3, 5'd2, 5'd1};
    @(posedge clk); #1;
    v_b = 0; we_b = 0; br_b = 0; waddr_b = 0; #4;
    chk("b_s1_valid_masked", 128'(s1_b), 128'(4'b0111));
    chk("b_redirect_valid", 128'(rv_b), 128'(1'b1));
    chk("b_redirect_lane", 128'(rl_b), 128'(2'd2));
    chk("b_redirect_pc", 128'(rpc_b), 128'(32'h1C00_0300));
    @(posedge clk); #4;
    chk("b_s1_bubble", 128'(s1_b), 128'(4'b0000));
    chk("b_mid_valid", 128'(midv_b), 128'(4'b0111));
    chk("b_mid_we", 128'(midwe_b), 128'(4'b0111));
    chk("b_redirect_once", 128'(rv_b), 128'(1'b0));
    @(posedge clk); #4;
    chk("b_wb_we", 128'(wbwe_b), 128'(4'b0111));
    chk("b_wb_waddr", 128'(wbwa_b), 128'({5'd4, 5'd3, 5'd2, 5'd1}));
    @(posedge clk); #1;
    v_b = 4'hF; we_b = 4'hF; waddr_b = {5'd8, 5'd7, 5'd6, 5'd5};
    @(posedge clk); #1;
    v_b = 0; we_b = 0; waddr_b = 0;
    @(posedge clk); #1;
    // reset asserted mid-run while new lanes are offered
    rstn_b = 0; v_b = 4'hF; we_b = 4'hF; #4;
    chk("b_mid_valid_before_reset", 128'(midv_b), 128'(4'hF));
    @(posedge clk); #1;
    rstn_b = 1; v_b = 0; we_b = 0; #4;
    chk("b_after_reset_s1", 128'(s1_b), 128'(4'b0000));
    chk("b_after_reset_mid", 128'(midv_b), 128'(4'b0000));
    chk("b_after_reset_wb_we", 128'(wbwe_b), 128'(4'b0000));
    @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
